// File: rtl/decode_pkg.sv
// decode_pkg: opcode map, control-word layout and the opcode-to-control
// translation shared by the decode and execute stages.
package decode_pkg;

    localparam int OPW = 7;

    localparam logic [6:0] OP_MOVA = 7'h00;
    localparam logic [6:0] OP_INC  = 7'h01;
    localparam logic [6:0] OP_ADD  = 7'h02;
    localparam logic [6:0] OP_SLT  = 7'h03;
    localparam logic [6:0] OP_SUB  = 7'h05;
    localparam logic [6:0] OP_DEC  = 7'h06;
    localparam logic [6:0] OP_AND  = 7'h08;
    localparam logic [6:0] OP_OR   = 7'h09;
    localparam logic [6:0] OP_XOR  = 7'h0A;
    localparam logic [6:0] OP_NOT  = 7'h0B;
    localparam logic [6:0] OP_MOVB = 7'h0C;
    localparam logic [6:0] OP_SHR  = 7'h0D;
    localparam logic [6:0] OP_SHL  = 7'h0E;
    localparam logic [6:0] OP_LD   = 7'h10;
    localparam logic [6:0] OP_ST   = 7'h20;
    localparam logic [6:0] OP_NOP  = 7'h30;
    localparam logic [6:0] OP_ADI  = 7'h42;
    localparam logic [6:0] OP_SBI  = 7'h45;
    localparam logic [6:0] OP_ANI  = 7'h48;
    localparam logic [6:0] OP_ORI  = 7'h49;
    localparam logic [6:0] OP_XRI  = 7'h4A;
    localparam logic [6:0] OP_LDI  = 7'h4C;
    localparam logic [6:0] OP_BRZ  = 7'h60;
    localparam logic [6:0] OP_BRN  = 7'h61;
    localparam logic [6:0] OP_JMP  = 7'h70;
    localparam logic [6:0] OP_JML  = 7'h72;

    typedef struct packed {
        logic       rw;
        logic [1:0] md;
        logic [1:0] bs;
        logic       ps;
        logic       mw;
        logic [3:0] fs;
        logic       mb;
        logic       ma;
        logic       cs;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{rw: 1'b0, md: 2'b00, bs: 2'b00, ps: 1'b0, mw: 1'b0,
                                   fs: 4'b0000, mb: 1'b0, ma: 1'b0, cs: 1'b0};

    // Control word for an opcode; function select mirrors the low opcode bits.
    function automatic ctrl_t op_to_ctrl(input logic [6:0] op);
        ctrl_t c;
        c    = CTRL_NOP;
        c.fs = op[3:0];
        case (op)
            OP_MOVA, OP_INC, OP_ADD, OP_SLT, OP_SUB, OP_DEC, OP_AND,
            OP_OR, OP_XOR, OP_NOT, OP_MOVB, OP_SHR, OP_SHL: c.rw = 1'b1;
            OP_LD:  begin c.rw = 1'b1; c.md = 2'b01; end
            OP_ST:  c.mw = 1'b1;
            OP_NOP: c = CTRL_NOP;
            OP_ADI, OP_SBI: begin c.rw = 1'b1; c.mb = 1'b1; c.cs = 1'b1; end
            OP_ANI, OP_ORI, OP_XRI, OP_LDI: begin c.rw = 1'b1; c.mb = 1'b1; end
            OP_BRZ: begin c.bs = 2'b01; c.mb = 1'b1; c.cs = 1'b1; end
            OP_BRN: begin c.bs = 2'b01; c.ps = 1'b1; c.mb = 1'b1; c.cs = 1'b1; end
            OP_JMP: c.bs = 2'b10;
            OP_JML: begin c.rw = 1'b1; c.ma = 1'b1; c.bs = 2'b10; end
            default: c = CTRL_NOP;
        endcase
        return c;
    endfunction

    // True when the opcode appears in the table above.
    function automatic logic op_listed(input logic [6:0] op);
        case (op)
            OP_MOVA, OP_INC, OP_ADD, OP_SLT, OP_SUB, OP_DEC, OP_AND, OP_OR,
            OP_XOR, OP_NOT, OP_MOVB, OP_SHR, OP_SHL, OP_LD, OP_ST, OP_NOP,
            OP_ADI, OP_SBI, OP_ANI, OP_ORI, OP_XRI, OP_LDI, OP_BRZ, OP_BRN,
            OP_JMP, OP_JML: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic src_uses_a(input logic [6:0] op);
        return !((op == OP_NOP) || (op == OP_MOVB));
    endfunction

    // B is only read as a register when the B-mux is not selecting an immediate.
    function automatic logic src_uses_b(input logic [6:0] op, input logic mb);
        case (op)
            OP_MOVB, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ST, OP_SLT: return !mb;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// decode_scoreboard: shift register of in-flight writeback destinations.
// Entry 0 takes the retiring destination (or a bubble); entries age by one
// position every clock and fall off after HAZ_DEPTH cycles.
module decode_scoreboard
    import decode_pkg::*;
#(
    parameter int RAW       = 5,
    parameter int HAZ_DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push_valid,
    input  logic [RAW-1:0] push_addr,
    input  logic [RAW-1:0] src_a,
    input  logic [RAW-1:0] src_b,
    output logic           hit_a,
    output logic           hit_b
);

    logic [HAZ_DEPTH-1:0] v_q;
    logic [HAZ_DEPTH-1:0] v_d;
    logic [RAW-1:0]       addr_q [HAZ_DEPTH];
    logic [RAW-1:0]       addr_d [HAZ_DEPTH];

    // Next entries: register 0 never occupies a slot, older entries shift up.
    always_comb begin
        v_d[0]    = push_valid && (push_addr != {RAW{1'b0}});
        addr_d[0] = push_addr;
        for (int i = 1; i < HAZ_DEPTH; i++) begin
            v_d[i]    = v_q[i-1];
            addr_d[i] = addr_q[i-1];
        end
    end

    // Match the two source fields against every live entry.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            hit_a = hit_a | (v_q[i] && (addr_q[i] == src_a));
            hit_b = hit_b | (v_q[i] && (addr_q[i] == src_b));
        end
    end

    // Entry storage; reset empties every slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= {HAZ_DEPTH{1'b0}};
            for (int i = 0; i < HAZ_DEPTH; i++) begin
                addr_q[i] <= {RAW{1'b0}};
            end
        end else begin
            v_q    <= v_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: splits an instruction into register fields and a control
// word, holds it in a valid/ready output register and interlocks on
// read-after-write hazards against the held word and the scoreboard.
// Build option DECODE_ILLEGAL_TRAP_EN: unlisted opcodes raise `illegal`
// (otherwise they decode silently as NOP and `illegal` stays 0).
module decode_stage
    import decode_pkg::*;
#(
    parameter int IW        = 32,
    parameter int RAW       = 5,
    parameter int HAZ_DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic [IW-1:0]  in_ir,
    output logic           in_ready,
    input  logic           flush,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [RAW-1:0] out_da,
    output logic [RAW-1:0] out_aa,
    output logic [RAW-1:0] out_ba,
    output logic           out_rw,
    output logic [1:0]     out_md,
    output logic [1:0]     out_bs,
    output logic           out_ps,
    output logic           out_mw,
    output logic [3:0]     out_fs,
    output logic           out_mb,
    output logic           out_ma,
    output logic           out_cs,
    output logic [15:0]    stall_cnt,
    output logic           illegal
);

    logic [6:0]     op_s;
    logic [RAW-1:0] da_s, aa_s, ba_s;
    ctrl_t          ctrl_dec_s;
    logic           use_a_s, use_b_s, illegal_dec_s;
    logic           sb_hit_a_s, sb_hit_b_s, blk_a_s, blk_b_s;
    logic           hazard_s, in_ready_s, accept_s, sb_push_s;
    logic [IW-1:0]  unused_ir_s;

    logic           out_valid_q, out_valid_d;
    ctrl_t          ctrl_q, ctrl_d;
    logic [RAW-1:0] da_q, da_d, aa_q, aa_d, ba_q, ba_d;
    logic           illegal_q, illegal_d;
    logic [15:0]    stall_cnt_q, stall_cnt_d;

    // The low instruction bits below BA carry no decode information.
    assign unused_ir_s = in_ir;

    // Field extraction and table lookup for the incoming instruction.
    always_comb begin
        op_s       = in_ir[IW-1 -: 7];
        da_s       = in_ir[IW-8 -: RAW];
        aa_s       = in_ir[IW-8-RAW -: RAW];
        ba_s       = in_ir[IW-8-2*RAW -: RAW];
        ctrl_dec_s = op_to_ctrl(op_s);
        use_a_s    = src_uses_a(op_s);
        use_b_s    = src_uses_b(op_s, ctrl_dec_s.mb);
`ifdef DECODE_ILLEGAL_TRAP_EN
        illegal_dec_s = ~op_listed(op_s);
`else
        illegal_dec_s = 1'b0;
`endif
    end

    // Hazard detection, handshake and scoreboard push.
    always_comb begin
        blk_a_s    = (aa_s != {RAW{1'b0}}) &&
                     (sb_hit_a_s || (out_valid_q && ctrl_q.rw && (da_q == aa_s)));
        blk_b_s    = (ba_s != {RAW{1'b0}}) &&
                     (sb_hit_b_s || (out_valid_q && ctrl_q.rw && (da_q == ba_s)));
        hazard_s   = (use_a_s && blk_a_s) || (use_b_s && blk_b_s);
        in_ready_s = (!out_valid_q || out_ready) && !hazard_s && !flush;
        accept_s   = in_valid && in_ready_s;
        sb_push_s  = out_valid_q && out_ready && ctrl_q.rw && (da_q != {RAW{1'b0}});
    end

    // Output register: flush discards, accept loads, a taken word drains.
    always_comb begin
        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        da_d        = da_q;
        aa_d        = aa_q;
        ba_d        = ba_q;
        illegal_d   = illegal_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept_s) begin
            out_valid_d = 1'b1;
            ctrl_d      = ctrl_dec_s;
            da_d        = da_s;
            aa_d        = aa_s;
            ba_d        = ba_s;
            illegal_d   = illegal_dec_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Saturating count of cycles an offered instruction waited on a hazard.
    always_comb begin
        if (in_valid && hazard_s && !flush && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State flops for the held decode and the stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= CTRL_NOP;
            da_q        <= {RAW{1'b0}};
            aa_q        <= {RAW{1'b0}};
            ba_q        <= {RAW{1'b0}};
            illegal_q   <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            da_q        <= da_d;
            aa_q        <= aa_d;
            ba_q        <= ba_d;
            illegal_q   <= illegal_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    decode_scoreboard #(
        .RAW       (RAW),
        .HAZ_DEPTH (HAZ_DEPTH)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (sb_push_s),
        .push_addr  (da_q),
        .src_a      (aa_s),
        .src_b      (ba_s),
        .hit_a      (sb_hit_a_s),
        .hit_b      (sb_hit_b_s)
    );

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_da    = da_q;
    assign out_aa    = aa_q;
    assign out_ba    = ba_q;
    assign out_rw    = ctrl_q.rw;
    assign out_md    = ctrl_q.md;
    assign out_bs    = ctrl_q.bs;
    assign out_ps    = ctrl_q.ps;
    assign out_mw    = ctrl_q.mw;
    assign out_fs    = ctrl_q.fs;
    assign out_mb    = ctrl_q.mb;
    assign out_ma    = ctrl_q.ma;
    assign out_cs    = ctrl_q.cs;
    assign stall_cnt = stall_cnt_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios followed by randomized traffic, all
// checked against a register-busy-timer reference model.
module tb_decode_stage;

    localparam int IW  = 32;
    localparam int RAW = 5;
    localparam int HD  = 2;

    localparam logic [6:0] T_ADD = 7'h02;
    localparam logic [6:0] T_SUB = 7'h05;
    localparam logic [6:0] T_OR  = 7'h09;
    localparam logic [6:0] T_LD  = 7'h10;
    localparam logic [6:0] T_BAD = 7'h7F;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic [IW-1:0]  in_ir = 32'd0;
    logic           in_ready;
    logic           flush = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [RAW-1:0] out_da, out_aa, out_ba;
    logic           out_rw, out_ps, out_mw, out_mb, out_ma, out_cs, illegal;
    logic [1:0]     out_md, out_bs;
    logic [3:0]     out_fs;
    logic [15:0]    stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: held word plus per-register busy timers.
    bit         m_ov;
    logic [6:0] m_op;
    logic [4:0] m_da, m_aa, m_ba;
    int         busy [32];
    int         m_stall;
    bit         s_rdy, last_acc;

    // 26 listed opcodes followed by one unlisted one.
    logic [6:0] ops [27] = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h05, 7'h06, 7'h08, 7'h09, 7'h0A,
                             7'h0B, 7'h0C, 7'h0D, 7'h0E, 7'h10, 7'h20, 7'h30, 7'h42, 7'h45,
                             7'h48, 7'h49, 7'h4A, 7'h4C, 7'h60, 7'h61, 7'h70, 7'h72, 7'h7F};

    decode_stage #(.IW(IW), .RAW(RAW), .HAZ_DEPTH(HD)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ir(in_ir), .in_ready(in_ready),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_da(out_da), .out_aa(out_aa), .out_ba(out_ba),
        .out_rw(out_rw), .out_md(out_md), .out_bs(out_bs), .out_ps(out_ps), .out_mw(out_mw),
        .out_fs(out_fs), .out_mb(out_mb), .out_ma(out_ma), .out_cs(out_cs),
        .stall_cnt(stall_cnt), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Expected {rw,md,bs,ps,mw,fs,mb,ma,cs} for an opcode.
    function automatic logic [13:0] exp_ctrl(input logic [6:0] op);
        logic rw, ps, mw, mb, ma, cs;
        logic [1:0] md, bs;
        logic [3:0] fs;
        {rw, ps, mw, mb, ma, cs} = 6'b0;
        md = 2'b00;
        bs = 2'b00;
        fs = op[3:0];
        case (op)
            7'h00, 7'h01, 7'h02, 7'h03, 7'h05, 7'h06, 7'h08, 7'h09, 7'h0A,
            7'h0B, 7'h0C, 7'h0D, 7'h0E: rw = 1'b1;
            7'h10: begin rw = 1'b1; md = 2'b01; end
            7'h20: mw = 1'b1;
            7'h30: begin end
            7'h42, 7'h45: begin rw = 1'b1; mb = 1'b1; cs = 1'b1; end
            7'h48, 7'h49, 7'h4A, 7'h4C: begin rw = 1'b1; mb = 1'b1; end
            7'h60: begin bs = 2'b01; mb = 1'b1; cs = 1'b1; end
            7'h61: begin bs = 2'b01; ps = 1'b1; mb = 1'b1; cs = 1'b1; end
            7'h70: bs = 2'b10;
            7'h72: begin rw = 1'b1; ma = 1'b1; bs = 2'b10; end
            default: fs = 4'b0000;
        endcase
        return {rw, md, bs, ps, mw, fs, mb, ma, cs};
    endfunction

    function automatic bit exp_listed(input logic [6:0] op);
        for (int i = 0; i < 26; i++) if (ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_illegal(input logic [6:0] op);
`ifdef DECODE_ILLEGAL_TRAP_EN
        return !exp_listed(op);
`else
        return (op == 7'h7F) && 1'b0;
`endif
    endfunction

    function automatic bit blocked(input logic [4:0] r);
        logic [13:0] hc;
        hc = exp_ctrl(m_op);
        return (r != 5'd0) && ((busy[r] > 0) || (m_ov && hc[13] && (m_da == r)));
    endfunction

    function automatic bit model_hazard(input logic [31:0] ir);
        logic [6:0] op;
        logic [13:0] c;
        bit ua, ub;
        op = ir[31:25];
        c  = exp_ctrl(op);
        ua = !(op == 7'h30 || op == 7'h0C);
        ub = (op == 7'h0C || op == 7'h02 || op == 7'h05 || op == 7'h08 || op == 7'h09 ||
              op == 7'h0A || op == 7'h20 || op == 7'h03) && !c[2];
        return (ua && blocked(ir[19:15])) || (ub && blocked(ir[14:10]));
    endfunction

    function automatic logic [31:0] enc(input logic [6:0] op, input int d, input int a, input int b);
        logic [9:0] junk;
        junk = 10'($urandom);
        return {op, 5'(d), 5'(a), 5'(b), junk};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at posedge+1, compare at negedge, advance the model.
    task automatic step(input bit v, input logic [31:0] ir, input bit ordy, input bit fl);
        bit haz, erdy, push;
        logic [13:0] hc;
        in_valid = v; in_ir = ir; out_ready = ordy; flush = fl;
        @(negedge clk);
        haz   = model_hazard(ir);
        erdy  = (!m_ov || ordy) && !haz && !fl;
        s_rdy = in_ready;
        chk("in_ready", {31'd0, in_ready}, {31'd0, erdy});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        chk("stall_cnt", {16'd0, stall_cnt}, 32'(m_stall));
        if (m_ov) begin
            chk("regs", {17'd0, out_da, out_aa, out_ba}, {17'd0, m_da, m_aa, m_ba});
            chk("ctrl", {18'd0, out_rw, out_md, out_bs, out_ps, out_mw, out_fs, out_mb, out_ma, out_cs},
                {18'd0, exp_ctrl(m_op)});
            chk("illegal", {31'd0, illegal}, {31'd0, exp_illegal(m_op)});
        end
        hc   = exp_ctrl(m_op);
        push = m_ov && ordy && hc[13] && (m_da != 5'd0);
        for (int r = 0; r < 32; r++) if (busy[r] > 0) busy[r]--;
        if (push) busy[m_da] = HD;
        if (v && haz && !fl && m_stall < 65535) m_stall++;
        last_acc = v && erdy;
        if (fl) m_ov = 1'b0;
        else if (last_acc) begin
            m_ov = 1'b1; m_op = ir[31:25]; m_da = ir[24:20]; m_aa = ir[19:15]; m_ba = ir[14:10];
        end else if (ordy) m_ov = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ctrl", {18'd0, out_rw, out_md, out_bs, out_ps, out_mw, out_fs, out_mb, out_ma, out_cs}, 32'd0);
        chk("rst_regs", {17'd0, out_da, out_aa, out_ba}, 32'd0);
        chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        m_ov = 1'b0; m_stall = 0; m_op = 7'h30;
        for (int r = 0; r < 32; r++) busy[r] = 0;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] cur;
        do_reset();

        // ADD R3,R1,R2: one-cycle latency, ALU control word.
        step(1'b1, enc(T_ADD, 3, 1, 2), 1'b1, 1'b0);
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_rw", {31'd0, out_rw}, 32'd1);
        chk("add_fs", {28'd0, out_fs}, 32'd2);
        chk("add_da", {27'd0, out_da}, 32'd3);
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1, 1'b0);

        // ADD R3 then dependent SUB R4,R3,R1: three stall cycles.
        do_reset();
        step(1'b1, enc(T_ADD, 3, 1, 2), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, enc(T_SUB, 4, 3, 1), 1'b1, 1'b0);
            chk("raw_stall", {31'd0, s_rdy}, 32'd0);
        end
        step(1'b1, enc(T_SUB, 4, 3, 1), 1'b1, 1'b0);
        chk("sub_issue", {31'd0, s_rdy}, 32'd1);
        chk("stall_three", {16'd0, stall_cnt}, 32'd3);
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1, 1'b0);

        // Writes to / reads of R0 never interlock.
        step(1'b1, enc(T_ADD, 0, 1, 2), 1'b1, 1'b0);
        step(1'b1, enc(T_OR, 5, 0, 0), 1'b1, 1'b0);
        chk("r0_no_stall", {31'd0, s_rdy}, 32'd1);
        chk("r0_stall_cnt", {16'd0, stall_cnt}, 32'd3);
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1, 1'b0);

        // LD held under backpressure for four cycles.
        step(1'b1, enc(T_LD, 6, 1, 0), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, enc(T_ADD, 7, 1, 2), 1'b0, 1'b0);
            chk("bp_ready", {31'd0, s_rdy}, 32'd0);
            chk("bp_md", {30'd0, out_md}, 32'd1);
            chk("bp_da", {27'd0, out_da}, 32'd6);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
        end
        step(1'b1, enc(T_ADD, 7, 1, 2), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1, 1'b0);

        // Flush drops the held word and refuses the offered instruction.
        step(1'b1, enc(T_ADD, 9, 1, 2), 1'b1, 1'b0);
        step(1'b1, enc(T_ADD, 8, 1, 2), 1'b1, 1'b1);
        chk("flush_ready", {31'd0, s_rdy}, 32'd0);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        step(1'b1, enc(T_ADD, 8, 1, 2), 1'b1, 1'b0);
        chk("after_flush_accept", {31'd0, s_rdy}, 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1, 1'b0);

        // Unlisted opcode decodes as NOP.
        step(1'b1, enc(T_BAD, 10, 1, 2), 1'b1, 1'b0);
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk("bad_illegal", {31'd0, illegal}, 32'd1);
`else
        chk("bad_illegal", {31'd0, illegal}, 32'd0);
`endif
        chk("bad_rw", {31'd0, out_rw}, 32'd0);
        chk("bad_mw", {31'd0, out_mw}, 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b0);

        // Reset while a dependent instruction is stalled behind a held LD.
        step(1'b1, enc(T_LD, 11, 1, 0), 1'b1, 1'b0);
        step(1'b1, enc(T_ADD, 12, 11, 2), 1'b0, 1'b0);
        chk("pre_rst_stall", {31'd0, s_rdy}, 32'd0);
        do_reset();
        step(1'b1, enc(T_ADD, 12, 11, 2), 1'b1, 1'b0);
        chk("post_rst_ready", {31'd0, s_rdy}, 32'd1);

        // Randomized traffic over a small register set to provoke hazards.
        cur = enc(ops[$urandom_range(0, 26)], $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        for (int n = 0; n < 500; n++) begin
            step($urandom_range(0, 3) != 0, cur, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
            if (last_acc) begin
                cur = enc(ops[$urandom_range(0, 26)], $urandom_range(0, 7),
                          $urandom_range(0, 7), $urandom_range(0, 7));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have parameter IW, default 32, meaning instruction width; IW >= 7 + 3*RAW.
REQ-002 The block SHALL have parameter RAW, default 5, meaning register-address width.
REQ-003 The block SHALL have parameter HAZ_DEPTH, default 2, meaning in-flight writeback stages tracked (1..4).
REQ-004 The block SHALL have these ports, with one clock and an asynchronous, active-low reset:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction present.
- in_ir  in  IW  instruction.
- in_ready  out  1  instruction accepted this cycle.
- flush  in  1  discard the held decode.
- out_valid  out  1  decoded word valid.
- out_ready  in  1  downstream accepts.
- out_da/out_aa/out_ba  out  RAW each  register fields.
- out_rw, out_md[1:0], out_bs[1:0], out_ps, out_mw, out_fs[3:0], out_mb, out_ma, out_cs  out  control word.
- stall_cnt  out  16  hazard-stall cycle count.
- illegal  out  1  held opcode unrecognised.

Function
REQ-005 Field extraction SHALL be: opcode=in_ir[IW-1:IW-7], DA next RAW bits below, AA next RAW, BA next RAW; the remaining low bits are ignored.
REQ-006 The control word per opcode SHALL come from the 26-entry opcode table in decode_pkg; fs defaults to opcode[3:0] and all other fields default to 0.
REQ-007 Source usage SHALL be:
- uses_a = opcode not in {NOP, MOVB}.
- uses_b = (mb==0) and opcode in {MOVB, ADD, SUB, AND, OR, XOR, ST, SLT}.
REQ-008 The scoreboard SHALL hold HAZ_DEPTH entries {v, addr} and shift one position every clock.
- Entry 0 loads {1, out_da} when out_valid && out_ready && out_rw && out_da!=0.
- Otherwise entry 0 loads a bubble {0, x}.
REQ-009 The hazard signal SHALL assert when a used source (AA or BA, nonzero) equals either:
- any valid scoreboard addr, or
- out_da of the held word while out_valid && out_rw.
REQ-010 Ready SHALL be: in_ready = (!out_valid || out_ready) && !hazard && !flush.
REQ-011 On in_valid && in_ready the output register SHALL load the decoded word and set out_valid next cycle, giving 1-cycle latency.
REQ-012 When out_valid && out_ready and nothing is loaded, out_valid SHALL clear; the held word SHALL be stable while out_valid && !out_ready.
REQ-013 flush SHALL clear out_valid next cycle and block acceptance that cycle; flush wins over accept; scoreboard contents are unaffected.
REQ-014 stall_cnt SHALL increment each cycle with in_valid && hazard && !flush and saturate at 0xFFFF.
REQ-015 Register 0 SHALL never cause a hazard or occupy a scoreboard entry.

Reset
REQ-016 Asserting rst_n low SHALL asynchronously force these outputs to 0: out_valid, all control fields, out_da/aa/ba, illegal, stall_cnt, and all scoreboard v bits.
REQ-017 Reset mid-stall SHALL drop the held word; the first cycle after release has in_ready = 1.

Configuration
REQ-018 With DECODE_ILLEGAL_TRAP_EN defined, an unlisted opcode SHALL load a NOP control word with illegal=1, held with the word.
REQ-019 Without DECODE_ILLEGAL_TRAP_EN, an unlisted opcode SHALL decode as NOP and illegal SHALL be tied 0.

Structure
REQ-020 decode_pkg SHALL hold the opcode localparams, the control-word struct typedef, and the opcode-to-control function, shared with the execute stage.
REQ-021 The scoreboard SHALL be sub-module decode_scoreboard, parametrised by RAW and HAZ_DEPTH.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- ADD R3,R1,R2 with out_ready=1 -> next cycle out_valid=1, rw=1, fs=4'b0010, da=3.
- ADD R3,R1,R2 then SUB R4,R3,R1 back-to-back, HAZ_DEPTH=2 -> in_ready=0 for 3 cycles, then SUB issues; stall_cnt=3.
- ADD R0,R1,R2 then OR R5,R0,R0 -> no stall.
- out_ready=0 for 4 cycles with LD held -> outputs stable, md=01, in_ready=0.
- flush asserted with in_valid=1 -> next cycle out_valid=0, instruction not consumed.
- opcode 7'b111_1111 with DECODE_ILLEGAL_TRAP_EN -> illegal=1, rw=0, mw=0.
